// File: rtl/mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : mem_arbiter
// Description : Two-master round-robin arbiter onto a single shared slave bus.
//               One transaction in flight at a time, with an optional slave
//               wait timeout that completes the request with ERR_DATA and
//               raises a sticky timeout_flag.
// Revision    : 1.0 - initial release
// ============================================================================
module mem_arbiter #(
  parameter int          TIMEOUT  = 1024,
  parameter logic [31:0] ERR_DATA = 32'hDEAD_BEEF
) (
  input  logic        clk,
  input  logic        resetn,
  // master 0
  input  logic        m0_valid,
  output logic        m0_ready,
  input  logic [31:0] m0_addr,
  input  logic [31:0] m0_wdata,
  input  logic [3:0]  m0_wstrb,
  output logic [31:0] m0_rdata,
  // master 1
  input  logic        m1_valid,
  output logic        m1_ready,
  input  logic [31:0] m1_addr,
  input  logic [31:0] m1_wdata,
  input  logic [3:0]  m1_wstrb,
  output logic [31:0] m1_rdata,
  // shared slave
  output logic        s_valid,
  input  logic        s_ready,
  output logic [31:0] s_addr,
  output logic [31:0] s_wdata,
  output logic [3:0]  s_wstrb,
  input  logic [31:0] s_rdata,
  // timeout status
  input  logic        timeout_clr,
  output logic        timeout_flag
);

  // A zero TIMEOUT disables the timeout; keep the counter at least one bit wide.
  localparam int            C_CW       = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam bit            C_TO_EN    = (TIMEOUT != 0);
  localparam logic [C_CW-1:0] C_CNT_LAST = (TIMEOUT > 0) ? C_CW'(TIMEOUT - 1) : '0;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_t;

  state_t          r_state;
  state_t          w_state_next;
  logic            r_grant;
  logic            w_grant_next;
  logic            r_last_grant;
  logic            w_last_grant_next;
  logic [C_CW-1:0] r_count;
  logic [C_CW-1:0] w_count_next;
  logic            r_timeout_flag;
  logic            w_flag_next;

  logic            w_busy;
  logic            w_timeout;
  logic            w_done;
  logic [31:0]     w_done_rdata;

  // Gating with resetn keeps the slave and master handshakes quiet while
  // reset is held, even before the reset edge has cleared the state.
  assign w_busy       = (r_state == BUSY) && resetn;
  // A slave response in the timeout cycle takes priority over the timeout.
  assign w_timeout    = C_TO_EN && w_busy && !s_ready && (r_count == C_CNT_LAST);
  assign w_done       = w_busy && (s_ready || w_timeout);
  assign w_done_rdata = s_ready ? s_rdata : ERR_DATA;

  assign s_valid = w_busy;
  assign s_addr  = w_busy ? (r_grant ? m1_addr  : m0_addr)  : '0;
  assign s_wdata = w_busy ? (r_grant ? m1_wdata : m0_wdata) : '0;
  assign s_wstrb = w_busy ? (r_grant ? m1_wstrb : m0_wstrb) : '0;

  assign m0_ready = w_done && !r_grant;
  assign m1_ready = w_done &&  r_grant;
  assign m0_rdata = m0_ready ? w_done_rdata : '0;
  assign m1_rdata = m1_ready ? w_done_rdata : '0;

  assign timeout_flag = r_timeout_flag;

  // Next-state logic: arbitrate in IDLE, count slave wait cycles in BUSY.
  always_comb begin
    w_state_next      = r_state;
    w_grant_next      = r_grant;
    w_last_grant_next = r_last_grant;
    w_count_next      = r_count;
    case (r_state)
      IDLE: begin
        w_count_next = '0;
        if (m0_valid || m1_valid) begin
          w_state_next = BUSY;
          // On contention the master that was not served last wins.
          w_grant_next = (m0_valid && m1_valid) ? !r_last_grant : m1_valid;
        end
      end
      BUSY: begin
        // Master valid is not consulted here: a started transaction always completes.
        if (w_done) begin
          w_state_next      = IDLE;
          w_last_grant_next = r_grant;
          w_count_next      = '0;
        end else begin
          w_count_next = r_count + 1'b1;
        end
      end
      default: begin
        w_state_next = IDLE;
        w_count_next = '0;
      end
    endcase
  end

  // Sticky timeout flag: a new timeout wins over a simultaneous clear.
  always_comb begin
    w_flag_next = r_timeout_flag;
    if (w_timeout) begin
      w_flag_next = 1'b1;
    end else if (timeout_clr) begin
      w_flag_next = 1'b0;
    end
  end

  // State registers; last_grant resets to 1 so m0 wins the first contention.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_state        <= IDLE;
      r_grant        <= 1'b0;
      r_last_grant   <= 1'b1;
      r_count        <= '0;
      r_timeout_flag <= 1'b0;
    end else begin
      r_state        <= w_state_next;
      r_grant        <= w_grant_next;
      r_last_grant   <= w_last_grant_next;
      r_count        <= w_count_next;
      r_timeout_flag <= w_flag_next;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_mem_arbiter
// Description : Self-checking bench for mem_arbiter. A transaction-level model
//               predicts slave requests, master completions and the timeout
//               flag; a monitor compares them against the DUT each cycle.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mem_arbiter;

  localparam int          TIMEOUT  = 8;
  localparam logic [31:0] ERR_DATA = 32'hDEAD_BEEF;

  logic        clk = 1'b0;
  logic        resetn;
  logic [1:0]  mv;
  logic [31:0] ma  [2];
  logic [31:0] mwd [2];
  logic [3:0]  mst [2];
  logic        m0_ready, m1_ready;
  logic [31:0] m0_rdata, m1_rdata;
  logic        s_valid, s_ready;
  logic [31:0] s_addr, s_wdata, s_rdata;
  logic [3:0]  s_wstrb;
  logic        timeout_clr, timeout_flag;

  mem_arbiter #(.TIMEOUT(TIMEOUT), .ERR_DATA(ERR_DATA)) dut (
    .clk(clk), .resetn(resetn),
    .m0_valid(mv[0]), .m0_ready(m0_ready), .m0_addr(ma[0]), .m0_wdata(mwd[0]),
    .m0_wstrb(mst[0]), .m0_rdata(m0_rdata),
    .m1_valid(mv[1]), .m1_ready(m1_ready), .m1_addr(ma[1]), .m1_wdata(mwd[1]),
    .m1_wstrb(mst[1]), .m1_rdata(m1_rdata),
    .s_valid(s_valid), .s_ready(s_ready), .s_addr(s_addr), .s_wdata(s_wdata),
    .s_wstrb(s_wstrb), .s_rdata(s_rdata),
    .timeout_clr(timeout_clr), .timeout_flag(timeout_flag)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- knobs (written by the main sequence only) --------------
  int          target [2];   // total requests each master should issue
  int          rate [2];     // percent chance per idle cycle to issue
  int          wr_mode [2];  // 0 random, 1 read, 2 full write
  bit          drop_busy [2];
  int          slave_mode;   // 0 random, 1 ready on BUSY cycle delay_n, 2 never
  int          delay_n;
  bit          fixed_en;
  logic [31:0] fixed_val;
  bit          clr_rand;

  // ---------------- master agent state ------------------------------------
  int issued [2];
  bit outstanding [2];

  // ---------------- scoreboard --------------------------------------------
  typedef struct { logic [31:0] addr; logic [31:0] wdata; logic [3:0] wstrb; int start; } sreq_t;
  typedef struct { int master; logic [31:0] rdata; int at; } resp_t;
  typedef struct { logic flag; logic sv; } stat_t;
  sreq_t sreq_q [$];
  resp_t resp_q [$];
  stat_t stat_q [$];

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h, expected %h (cycle %0d)", name, got, exp, cyc);
  endtask

  // Master agents: issue requests, hold them until the ready pulse.
  initial begin
    mv = '0;
    for (int m = 0; m < 2; m++) begin
      ma[m] = '0; mwd[m] = '0; mst[m] = '0; issued[m] = 0; outstanding[m] = 1'b0;
    end
    forever begin
      @(negedge clk);
      if (m0_ready) outstanding[0] = 1'b0;
      if (m1_ready) outstanding[1] = 1'b0;
      @(posedge clk); #1;
      for (int m = 0; m < 2; m++) begin
        if (!outstanding[m]) begin
          mv[m] = 1'b0;
          if (issued[m] < target[m] && int'($urandom_range(99)) < rate[m]) begin
            ma[m]  = $urandom;
            mwd[m] = $urandom;
            case (wr_mode[m])
              1:       mst[m] = 4'h0;
              2:       mst[m] = 4'hF;
              default: mst[m] = ($urandom_range(3) == 0) ? 4'h0 : 4'($urandom_range(15, 1));
            endcase
            mv[m] = 1'b1;
            outstanding[m] = 1'b1;
            issued[m]++;
          end
        end else if (drop_busy[m] && s_valid) begin
          mv[m] = 1'b0;
        end
      end
    end
  end

  // Slave agent.
  int sk = 0;
  initial begin
    s_ready = 1'b0;
    s_rdata = '0;
    forever begin
      @(posedge clk); #2;
      sk = s_valid ? sk + 1 : 0;
      case (slave_mode)
        1:       s_ready = s_valid && (sk == delay_n);
        2:       s_ready = 1'b0;
        default: s_ready = s_valid && (int'($urandom_range(99)) < 30);
      endcase
      s_rdata = fixed_en ? fixed_val : $urandom;
    end
  end

  // Reference model: transactions with a start cycle; timeout by elapsed cycles.
  bit mb_busy  = 1'b0;
  int mb_owner = 0;
  int mb_start = 0;
  int mb_last  = 1;
  bit mb_flag  = 1'b0;
  bit mb_set;
  initial begin
    forever begin
      @(negedge clk);
      if (cyc > 0) begin
        stat_q.push_back('{mb_flag, resetn && mb_busy});
        mb_set = 1'b0;
        if (!resetn) begin
          mb_busy = 1'b0; mb_last = 1; mb_flag = 1'b0;
        end else begin
          if (mb_busy) begin
            if (s_ready) begin
              resp_q.push_back('{mb_owner, s_rdata, cyc});
              mb_busy = 1'b0; mb_last = mb_owner;
            end else if (TIMEOUT != 0 && (cyc - mb_start + 1) == TIMEOUT) begin
              resp_q.push_back('{mb_owner, ERR_DATA, cyc});
              mb_busy = 1'b0; mb_last = mb_owner; mb_set = 1'b1;
            end
          end else if (mv != 2'b00) begin
            mb_owner = (mv == 2'b11) ? 1 - mb_last : (mv[1] ? 1 : 0);
            mb_busy  = 1'b1;
            mb_start = cyc + 1;
            sreq_q.push_back('{ma[mb_owner], mwd[mb_owner], mst[mb_owner], cyc + 1});
          end
          if (mb_set) mb_flag = 1'b1;
          else if (timeout_clr) mb_flag = 1'b0;
        end
      end
    end
  end

  // Monitor: compares DUT outputs against the queued expectations.
  stat_t       st;
  sreq_t       cur;
  resp_t       rp;
  logic        prev_sv = 1'b0;
  logic [1:0]  rdy;
  logic [31:0] rd [2];
  initial begin
    cur = '{32'h0, 32'h0, 4'h0, 0};
    forever begin
      @(negedge clk); #1;
      if (cyc > 0) begin
        check("status_avail", 32'(stat_q.size() > 0), 32'd1);
        if (stat_q.size() > 0) begin
          st = stat_q.pop_front();
          check("s_valid", 32'(s_valid), 32'(st.sv));
          check("timeout_flag", 32'(timeout_flag), 32'(st.flag));
        end
        if (s_valid && !prev_sv) begin
          check("sreq_avail", 32'(sreq_q.size() > 0), 32'd1);
          if (sreq_q.size() > 0) begin
            cur = sreq_q.pop_front();
            check("grant_latency", 32'(cyc), 32'(cur.start));
          end
        end
        if (s_valid) begin
          check("s_addr", s_addr, cur.addr);
          check("s_wdata", s_wdata, cur.wdata);
          check("s_wstrb", 32'(s_wstrb), 32'(cur.wstrb));
        end else begin
          check("s_idle_fields", s_addr | s_wdata | 32'(s_wstrb), 32'd0);
        end
        check("sreq_late", 32'(sreq_q.size() > 0 && sreq_q[0].start <= cyc), 32'd0);
        rdy   = {m1_ready, m0_ready};
        rd[0] = m0_rdata;
        rd[1] = m1_rdata;
        check("ready_exclusive", 32'(rdy == 2'b11), 32'd0);
        for (int m = 0; m < 2; m++) begin
          if (rdy[m]) begin
            check("resp_avail", 32'(resp_q.size() > 0), 32'd1);
            if (resp_q.size() > 0) begin
              rp = resp_q.pop_front();
              check("resp_master", 32'(m), 32'(rp.master));
              check("resp_rdata", rd[m], rp.rdata);
              check("resp_cycle", 32'(cyc), 32'(rp.at));
            end
          end else begin
            check("rdata_quiet", rd[m], 32'd0);
          end
        end
        check("resp_missing", 32'(resp_q.size() > 0 && resp_q[0].at <= cyc), 32'd0);
        prev_sv = s_valid;
      end
    end
  end

  // ---------------- main sequence -----------------------------------------
  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk); #1;
      if (clr_rand) timeout_clr = ($urandom_range(19) == 0);
    end
  endtask

  task automatic add_req(input int m, input int n);
    target[m] = issued[m] + n;
  endtask

  task automatic wait_done(input int budget, input string name);
    int w;
    w = 0;
    while ((outstanding[0] || outstanding[1] || issued[0] < target[0] ||
            issued[1] < target[1]) && w < budget) begin
      tick(1);
      w++;
    end
    check(name, 32'(w < budget), 32'd1);
    tick(2);
  endtask

  task automatic do_reset(input int n);
    resetn = 1'b0;
    tick(n);
    resetn = 1'b1;
    tick(1);
  endtask

  int sw;
  initial begin
    resetn = 1'b0; timeout_clr = 1'b0; clr_rand = 1'b0;
    slave_mode = 1; delay_n = 1; fixed_en = 1'b0; fixed_val = '0;
    for (int m = 0; m < 2; m++) begin
      target[m] = 0; rate[m] = 100; wr_mode[m] = 0; drop_busy[m] = 1'b0;
    end
    tick(3);
    resetn = 1'b1;
    tick(2);

    // Simultaneous reads after reset: m0 first, then m1; slave ready on 2nd BUSY cycle.
    wr_mode[0] = 1; wr_mode[1] = 1;
    delay_n = 2; fixed_en = 1'b1; fixed_val = 32'h1234_5678;
    add_req(0, 1); add_req(1, 1);
    wait_done(100, "wait_first_pair");

    // Continuous requests from both: alternation with one IDLE cycle between.
    fixed_en = 1'b0; delay_n = 1; wr_mode[0] = 0; wr_mode[1] = 0;
    add_req(0, 3); add_req(1, 3);
    wait_done(200, "wait_alternate");

    // m1 full write, slave never answers: timeout completion, sticky flag.
    wr_mode[1] = 2; slave_mode = 2;
    add_req(1, 1);
    wait_done(100, "wait_timeout");
    tick(4);
    timeout_clr = 1'b1;
    tick(1);
    timeout_clr = 1'b0;
    tick(2);

    // Timeout while clear is held: set wins that edge, clear takes the next.
    timeout_clr = 1'b1;
    add_req(1, 1);
    wait_done(100, "wait_timeout_clr");
    timeout_clr = 1'b0;

    // Slave answers exactly in the timeout cycle: normal completion.
    slave_mode = 1; delay_n = TIMEOUT; wr_mode[0] = 1;
    add_req(0, 1);
    wait_done(100, "wait_ready_at_limit");

    // m0 drops valid mid-transaction: completion still delivered.
    drop_busy[0] = 1'b1; delay_n = 3;
    add_req(0, 1);
    wait_done(100, "wait_drop_valid");
    drop_busy[0] = 1'b0;

    // Reset in the 2nd BUSY cycle drops the transaction; m0 is re-arbitrated.
    slave_mode = 2;
    add_req(0, 1);
    sw = 0;
    while (!s_valid && sw < 20) begin
      tick(1);
      sw++;
    end
    check("wait_busy_start", 32'(sw < 20), 32'd1);
    tick(1);
    resetn = 1'b0;
    tick(2);
    slave_mode = 1; delay_n = 2;
    resetn = 1'b1;
    wait_done(100, "wait_after_reset");

    // Fresh reset, then contention: m0 must win again.
    do_reset(2);
    add_req(0, 1); add_req(1, 1);
    wait_done(100, "wait_post_reset_pair");

    // Random traffic with random slave latency and random flag clears.
    slave_mode = 0; wr_mode[0] = 0; wr_mode[1] = 0;
    rate[0] = 40; rate[1] = 40; clr_rand = 1'b1;
    add_req(0, 120); add_req(1, 120);
    wait_done(20000, "wait_random");
    clr_rand = 1'b0; timeout_clr = 1'b0;
    tick(3);

    check("resp_leftover", 32'(resp_q.size()), 32'd0);
    check("sreq_leftover", 32'(sreq_q.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 SHALL have parameter TIMEOUT, default 1024, max slave-wait cycles before error completion; 0 disables timeout.
REQ-002 SHALL have parameter ERR_DATA, default 32'hDEAD_BEEF, read data returned on timeout completion.
REQ-003 SHALL have port clk  input  1  system clock, all logic on rising edge.
REQ-004 SHALL have port resetn  input  1  reset, synchronous, active-low.
REQ-005 SHALL have ports m0_valid/m1_valid  input  1  master request.
REQ-006 SHALL have ports m0_ready/m1_ready  output  1  one-cycle completion pulse to master.
REQ-007 SHALL have ports m0_addr/m1_addr  input  32  master address.
REQ-008 SHALL have ports m0_wdata/m1_wdata  input  32  master write data.
REQ-009 SHALL have ports m0_wstrb/m1_wstrb  input  4  byte strobes; 0 = read.
REQ-010 SHALL have ports m0_rdata/m1_rdata  output  32  read data to master.
REQ-011 SHALL have port s_valid  output  1  request to shared slave bus.
REQ-012 SHALL have port s_ready  input  1  slave completion.
REQ-013 SHALL have ports s_addr/s_wdata/s_wstrb  output  32/32/4  forwarded request fields.
REQ-014 SHALL have port s_rdata  input  32  slave read data.
REQ-015 SHALL have port timeout_clr  input  1  clears timeout_flag.
REQ-016 SHALL have port timeout_flag  output  1  sticky, set on any timeout completion.

Function
REQ-017 SHALL implement FSM with states IDLE and BUSY, plus registered grant (0/1) and last_grant.
REQ-018 IDLE: on one valid, grant that master; on both valid, grant the master != last_grant; transition to BUSY next edge.
REQ-019 Grant latency SHALL be exactly 1 cycle: s_valid rises the cycle after m*_valid is first sampled in IDLE.
REQ-020 BUSY: s_valid=1; s_addr/s_wdata/s_wstrb combinationally muxed from granted master; outside BUSY, s_valid=0 and s_addr/s_wdata/s_wstrb=0.
REQ-021 BUSY with s_ready=1: granted m*_ready=1 and m*_rdata=s_rdata that same cycle; last_grant<=grant; counter<=0; next state IDLE.
REQ-022 The non-granted master SHALL see ready=0 and rdata=0 at all times; the granted master SHALL see rdata=0 except in its ready cycle.
REQ-023 BUSY wait counter (width clog2(TIMEOUT+1)) SHALL increment each BUSY cycle with s_ready=0 and reset to 0 on leaving BUSY.
REQ-024 If TIMEOUT!=0, counter==TIMEOUT-1, and s_ready=0: granted m*_ready=1, m*_rdata=ERR_DATA, timeout_flag<=1, last_grant<=grant, next state IDLE.
REQ-025 s_ready and timeout in the same cycle SHALL complete normally, with s_rdata returned and the flag unchanged.
REQ-026 A master dropping valid mid-BUSY SHALL NOT abort; the transaction completes and the ready pulse is still issued.
REQ-027 Back-to-back transactions SHALL have one IDLE cycle between slave transactions; a continuously requesting pair alternates m0,m1,m0...
REQ-028 timeout_clr=1 SHALL clear timeout_flag next edge; simultaneous set and clear SHALL leave the flag set.

Reset
REQ-029 resetn=0 at an edge SHALL force state=IDLE, grant=0, last_grant=1, counter=0, and timeout_flag=0.
REQ-030 During and after reset, s_valid, m0_ready, and m1_ready SHALL be 0; a BUSY transaction interrupted by reset SHALL be dropped without a ready pulse.
REQ-031 After reset, on the first simultaneous request, m0 SHALL win.

Verification
REQ-032 After reset, m0 and m1 both valid, read, slave ready after 2 cycles with s_rdata=32'h1234_5678 -> m0_ready pulse, m0_rdata=32'h1234_5678; m1 is then served with s_addr=m1_addr.
REQ-033 Both masters held valid for 6 transactions, slave ready after 1 cycle -> grant order m0,m1,m0,m1,m0,m1, one IDLE cycle between each.
REQ-034 TIMEOUT=8, m1 write wstrb=4'hF, s_ready never -> m1_ready on the 8th BUSY cycle, m1_rdata=32'hDEAD_BEEF, timeout_flag=1 until timeout_clr.
REQ-035 TIMEOUT=8, s_ready asserted on the 8th BUSY cycle -> normal completion, timeout_flag stays 0.
REQ-036 resetn=0 in the 2nd BUSY cycle of an m0 request -> s_valid=0 next cycle, no m0_ready; after reset, the m0 request is re-arbitrated and completes.
